// File: rtl/pulse_stretcher.sv
// -----------------------------------------------------------------------------
// pulse_stretcher
//
// Turns single-cycle event strobes into a slow, human-visible level. Each
// event produces one high period of ON_CYCLES clocks, followed by a low gap of
// at least GAP_CYCLES clocks. Events that arrive while the output is busy are
// counted in a saturating pending counter and replayed one after another.
//
// Optional feature (compile-time macro PULSE_STRETCHER_RETRIGGER_EN):
//   defined   - a pulse during ON restarts the high period instead of queuing
//   undefined - a pulse during ON is queued like a pulse during GAP
//
// Parameters:
//   ON_CYCLES    high time per event in clk cycles (>= 1)
//   GAP_CYCLES   minimum low time after each high period (>= 1)
//   PEND_W       width of the pending-event counter (saturating)
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   pulse_in       event strobe; every high cycle is one event
//   overflow_clr   synchronous clear of overflow (a same-cycle set wins)
//   stretched_out  registered indicator output
//   busy           high while in ON or GAP
//   pending        queued events not yet shown
//   overflow       sticky flag: an event was dropped at saturation
// -----------------------------------------------------------------------------
module pulse_stretcher #(
  parameter int ON_CYCLES  = 256,
  parameter int GAP_CYCLES = 256,
  parameter int PEND_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pulse_in,
  input  logic              overflow_clr,
  output logic              stretched_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int MAX_CYC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0]  ON_LAST   = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [PEND_W-1:0] pend_nxt;
  logic              ovf_nxt;
  logic              pend_inc;
  logic              pend_dec;
  logic              ovf_evt;

  // Next-state, phase counter and queue bookkeeping
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    pend_inc  = 1'b0;
    pend_dec  = 1'b0;

    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (pulse_in) begin
          state_nxt = ST_ON;
        end
      end

      ST_ON: begin
        if (cnt == ON_LAST) begin
          state_nxt = ST_GAP;
          cnt_nxt   = '0;
        end
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        // Retrigger overrides the ON->GAP exit, even on the last ON cycle.
        if (pulse_in) begin
          state_nxt = ST_ON;
          cnt_nxt   = '0;
        end
`else
        pend_inc = pulse_in;
`endif
      end

      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt = '0;
          if (pending != '0) begin
            // Replay a queued event; a pulse arriving now takes its place in
            // the queue, so the two updates cancel below.
            state_nxt = ST_ON;
            pend_dec  = 1'b1;
            pend_inc  = pulse_in;
          end else if (pulse_in) begin
            state_nxt = ST_ON;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          pend_inc = pulse_in;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // A queued pulse is only dropped when it has nowhere to go.
    ovf_evt  = 1'b0;
    pend_nxt = pending;
    if (pend_inc && !pend_dec) begin
      if (pending == PEND_MAX) begin
        ovf_evt = 1'b1;
      end else begin
        pend_nxt = pending + PEND_W'(1);
      end
    end else if (pend_dec && !pend_inc) begin
      pend_nxt = pending - PEND_W'(1);
    end

    if (ovf_evt) begin
      ovf_nxt = 1'b1;
    end else if (overflow_clr) begin
      ovf_nxt = 1'b0;
    end else begin
      ovf_nxt = overflow;
    end
  end

  // State and registered outputs; outputs are derived from the next state so
  // they change on the same edge as the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      pending       <= '0;
      overflow      <= 1'b0;
      stretched_out <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      pending       <= pend_nxt;
      overflow      <= ovf_nxt;
      stretched_out <= (state_nxt == ST_ON);
      busy          <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// -----------------------------------------------------------------------------
// tb_pulse_stretcher
//
// Scoreboard bench for pulse_stretcher with ON_CYCLES=4, GAP_CYCLES=3,
// PEND_W=2. Each scenario pushes the expected high-period lengths into a
// queue; a monitor measures every high period of stretched_out and pops the
// expected length. Every low gap while busy must be exactly GAP_CYCLES long.
// Expectations follow PULSE_STRETCHER_RETRIGGER_EN when it is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pulse_stretcher;

  localparam int ON  = 4;
  localparam int GAP = 3;

  logic       clk;
  logic       rst_n;
  logic       pulse_in;
  logic       overflow_clr;
  logic       stretched_out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int hi_cnt  = 0;
  int gap_cnt = 0;

  pulse_stretcher #(
    .ON_CYCLES (ON),
    .GAP_CYCLES(GAP),
    .PEND_W    (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pulse_in     (pulse_in),
    .overflow_clr (overflow_clr),
    .stretched_out(stretched_out),
    .busy         (busy),
    .pending      (pending),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) check("idle_timeout", 0, 1);
    @(negedge clk);
    #1;
  endtask

  // Monitor: measure high periods and in-busy low gaps.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hi_cnt  = 0;
      gap_cnt = 0;
    end else begin
      if (stretched_out) begin
        hi_cnt++;
      end else if (hi_cnt != 0) begin
        if (exp_q.size() == 0) check("sb_unexpected_period", hi_cnt, 0);
        else check("hi_len", hi_cnt, exp_q.pop_front());
        hi_cnt = 0;
      end
      if (busy && !stretched_out) begin
        gap_cnt++;
      end else if (gap_cnt != 0) begin
        check("gap_len", gap_cnt, GAP);
        gap_cnt = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst_n        = 1'b0;
    pulse_in     = 1'b0;
    overflow_clr = 1'b0;
    repeat (3) tick();
    check("rst_stretched", int'(stretched_out), 0);
    check("rst_busy",      int'(busy), 0);
    check("rst_pending",   int'(pending), 0);
    check("rst_overflow",  int'(overflow), 0);
    rst_n = 1'b1;
    tick();

    // S1: single pulse from IDLE
    exp_q.push_back(ON);
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    check("s1_rise", int'(stretched_out), 1);
    check("s1_busy", int'(busy), 1);
    repeat (3) tick();
    check("s1_still_high", int'(stretched_out), 1);
    tick();
    check("s1_fall", int'(stretched_out), 0);
    check("s1_busy_in_gap", int'(busy), 1);
    wait_idle(40);
    check("s1_pending", int'(pending), 0);
    check("s1_drain", exp_q.size(), 0);

    // S2: three pulses on consecutive cycles
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    exp_q.push_back(6);
`else
    repeat (3) exp_q.push_back(ON);
`endif
    pulse_in = 1'b1;
    tick();
    tick();
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    check("s2_pend1", int'(pending), 0);
`else
    check("s2_pend1", int'(pending), 1);
`endif
    tick();
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    check("s2_pend2", int'(pending), 0);
`else
    check("s2_pend2", int'(pending), 2);
`endif
    pulse_in = 1'b0;
    wait_idle(80);
    check("s2_idle_pending", int'(pending), 0);
    check("s2_drain", exp_q.size(), 0);

    // S3: saturation, overflow, set-wins-over-clear, then clear
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    exp_q.push_back(9);
`else
    repeat (4) exp_q.push_back(ON);
`endif
    pulse_in = 1'b1;
    repeat (4) tick();
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    check("s3_pend_sat", int'(pending), 0);
`else
    check("s3_pend_sat", int'(pending), 3);
`endif
    tick();
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    check("s3_overflow", int'(overflow), 0);
`else
    check("s3_overflow", int'(overflow), 1);
`endif
    overflow_clr = 1'b1;
    tick();
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    check("s3_set_wins", int'(overflow), 0);
`else
    check("s3_set_wins", int'(overflow), 1);
`endif
    pulse_in = 1'b0;
    tick();
    check("s3_clr", int'(overflow), 0);
    overflow_clr = 1'b0;
    wait_idle(120);
    check("s3_drain", exp_q.size(), 0);

    // S4: pulse on the final GAP cycle with nothing pending
    exp_q.push_back(ON);
    exp_q.push_back(ON);
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    repeat (6) tick();
    check("s4_in_gap", int'(stretched_out), 0);
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    check("s4_reon", int'(stretched_out), 1);
    check("s4_busy", int'(busy), 1);
    check("s4_pending", int'(pending), 0);
    wait_idle(40);
    check("s4_drain", exp_q.size(), 0);

    // S5: pulse on ON cycle 3
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    exp_q.push_back(7);
`else
    exp_q.push_back(ON);
    exp_q.push_back(ON);
`endif
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    tick();
    tick();
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    check("s5_pending", int'(pending), 0);
`else
    check("s5_pending", int'(pending), 1);
`endif
    wait_idle(60);
    check("s5_drain", exp_q.size(), 0);

    // S6: asynchronous reset mid-ON with events queued
    pulse_in = 1'b1;
    repeat (3) tick();
    pulse_in = 1'b0;
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    check("s6_pend_before", int'(pending), 0);
`else
    check("s6_pend_before", int'(pending), 2);
`endif
    check("s6_high_before", int'(stretched_out), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("s6_async_stretched", int'(stretched_out), 0);
    check("s6_async_busy",      int'(busy), 0);
    check("s6_async_pending",   int'(pending), 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("s6_quiet_stretched", int'(stretched_out), 0);
    check("s6_quiet_busy",      int'(busy), 0);
    check("s6_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
